// File: rtl/mem_ctrl_seq.sv
// mem_ctrl_seq
// Hard-wired Moore control sequencer for the Mini SRC datapath.
// Covers ld, ldi, st, nop and halt. The unit fetches an instruction in
// F0..F2, decodes the opcode on the clock edge that leaves F2, and then
// steps through the execute states of that instruction. It issues one
// control word per clock.
//
// Every control output is decoded from the state register alone. An
// asynchronous clear therefore forces all outputs low in the same cycle,
// and a store that is in progress cannot complete its write.
//
// The opcode is decoded from IR_Data while the state is F2. The MDR drives
// the bus and loads the IR during F2, so the datapath must present the
// fetched word on IR_Data in that cycle: either through the bus value or
// through an IR register that is transparent on load.

module mem_ctrl_seq #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011,
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      IR_Data,
  output logic             PC_out,
  output logic             PC_in,
  output logic             IncPC,
  output logic             MAR_in,
  output logic             MDR_in,
  output logic             MDR_out,
  output logic             IR_in,
  output logic             Y_in,
  output logic             Z_in,
  output logic             Zlow_out,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             C_out,
  output logic [4:0]       alu_instruction_bits,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // State encoding
  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_F0   = 5'd1;
  localparam logic [4:0] S_F1   = 5'd2;
  localparam logic [4:0] S_F2   = 5'd3;
  localparam logic [4:0] S_LD3  = 5'd4;
  localparam logic [4:0] S_LD4  = 5'd5;
  localparam logic [4:0] S_LD5  = 5'd6;
  localparam logic [4:0] S_LD6  = 5'd7;
  localparam logic [4:0] S_LD7  = 5'd8;
  localparam logic [4:0] S_LI3  = 5'd9;
  localparam logic [4:0] S_LI4  = 5'd10;
  localparam logic [4:0] S_LI5  = 5'd11;
  localparam logic [4:0] S_ST3  = 5'd12;
  localparam logic [4:0] S_ST4  = 5'd13;
  localparam logic [4:0] S_ST5  = 5'd14;
  localparam logic [4:0] S_ST6  = 5'd15;
  localparam logic [4:0] S_HALT = 5'd16;
  localparam logic [4:0] S_ERR  = 5'd17;

  logic [4:0]       r_state;
  logic [4:0]       w_state_next;
  logic [4:0]       w_opcode;
  logic [4:0]       w_boundary_state;
  logic             w_retire;
  logic [CNT_W-1:0] r_count;
  logic             w_unused_ir;

  assign w_opcode    = IR_Data[31:27];
  assign w_unused_ir = ^IR_Data[26:0];

  // State to enter when an instruction finishes; run is only sampled here and in IDLE
  assign w_boundary_state = run ? S_F0 : S_IDLE;

  // An instruction retires when leaving LD7/LI5/ST6, or when a nop is decoded in F2
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_LD7, S_LI5, S_ST6: w_retire = 1'b1;
      S_F2:                w_retire = (w_opcode == OP_NOP);
      default:             w_retire = 1'b0;
    endcase
  end

  // Next-state logic: fetch, decode, per-instruction execute chains, sticky HALT/ERR
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = run ? S_F0 : S_IDLE;
      S_F0:   w_state_next = S_F1;
      S_F1:   w_state_next = S_F2;
      S_F2: begin
        if (w_opcode == OP_LD)        w_state_next = S_LD3;
        else if (w_opcode == OP_LDI)  w_state_next = S_LI3;
        else if (w_opcode == OP_ST)   w_state_next = S_ST3;
        else if (w_opcode == OP_NOP)  w_state_next = w_boundary_state;
        else if (w_opcode == OP_HALT) w_state_next = S_HALT;
        else                          w_state_next = S_ERR;
      end
      S_LD3:  w_state_next = S_LD4;
      S_LD4:  w_state_next = S_LD5;
      S_LD5:  w_state_next = S_LD6;
      S_LD6:  w_state_next = S_LD7;
      S_LD7:  w_state_next = w_boundary_state;
      S_LI3:  w_state_next = S_LI4;
      S_LI4:  w_state_next = S_LI5;
      S_LI5:  w_state_next = w_boundary_state;
      S_ST3:  w_state_next = S_ST4;
      S_ST4:  w_state_next = S_ST5;
      S_ST5:  w_state_next = S_ST6;
      S_ST6:  w_state_next = w_boundary_state;
      S_HALT: w_state_next = S_HALT;
      S_ERR:  w_state_next = S_ERR;
      // Unused encodings are treated as a fault and parked in ERR
      default: w_state_next = S_ERR;
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge clr) begin
    if (clr)           r_count <= '0;
    else if (w_retire) r_count <= r_count + 1'b1;
  end

  assign instr_count = r_count;

  // Moore output decode: one control word per state, all zero by default
  always_comb begin
    PC_out               = 1'b0;
    PC_in                = 1'b0;
    IncPC                = 1'b0;
    MAR_in               = 1'b0;
    MDR_in               = 1'b0;
    MDR_out              = 1'b0;
    IR_in                = 1'b0;
    Y_in                 = 1'b0;
    Z_in                 = 1'b0;
    Zlow_out             = 1'b0;
    Read                 = 1'b0;
    Write                = 1'b0;
    Gra                  = 1'b0;
    Grb                  = 1'b0;
    Rin                  = 1'b0;
    Rout                 = 1'b0;
    BAout                = 1'b0;
    C_out                = 1'b0;
    alu_instruction_bits = 5'b00000;
    halted               = 1'b0;
    illegal              = 1'b0;
    case (r_state)
      S_F0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
      end
      S_F1: begin
        Zlow_out = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
      end
      S_F2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
      end
      // Base-address step shared by ld/ldi/st: Y <= (Rb or 0)
      S_LD3, S_LI3, S_ST3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Y_in  = 1'b1;
      end
      // Effective-address add shared by ld/ldi/st: Z <= Y + sext(C)
      S_LD4, S_LI4, S_ST4: begin
        C_out                = 1'b1;
        alu_instruction_bits = ALU_ADD;
        Z_in                 = 1'b1;
      end
      S_LD5, S_ST5: begin
        Zlow_out = 1'b1;
        MAR_in   = 1'b1;
      end
      S_LD6: begin
        Read   = 1'b1;
        MDR_in = 1'b1;
      end
      S_LD7: begin
        MDR_out = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      S_LI5: begin
        Zlow_out = 1'b1;
        Gra      = 1'b1;
        Rin      = 1'b1;
      end
      S_ST6: begin
        Gra    = 1'b1;
        Rout   = 1'b1;
        MDR_in = 1'b1;
        Write  = 1'b1;
      end
      S_HALT: halted  = 1'b1;
      S_ERR:  illegal = 1'b1;
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// tb_mem_ctrl_seq
// Directed bench for mem_ctrl_seq. A small behavioural Mini SRC datapath
// (bus, PC, MAR, MDR, IR, Y, Z, register file, memory) is driven by the
// sequencer's control outputs. The bench checks each control word cycle by
// cycle, and it checks the architectural results of a short program.

module tb_mem_ctrl_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic [31:0] IR_Data;
  logic PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in;
  logic Zlow_out, Read, Write, Gra, Grb, Rin, Rout, BAout, C_out;
  logic [4:0]  alu_instruction_bits;
  logic        halted, illegal;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  int prog_sel = 0;

  always #5 clk = ~clk;

  mem_ctrl_seq dut (
    .clk(clk), .clr(clr), .run(run), .IR_Data(IR_Data),
    .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in),
    .MDR_in(MDR_in), .MDR_out(MDR_out), .IR_in(IR_in), .Y_in(Y_in),
    .Z_in(Z_in), .Zlow_out(Zlow_out), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .C_out(C_out), .alu_instruction_bits(alu_instruction_bits),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  // Packed control word: one bit per strobe, ALU code in the low 5 bits
  logic [24:0] word;
  assign word = {PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in,
                 Z_in, Zlow_out, Read, Write, Gra, Grb, Rin, Rout, BAout,
                 C_out, halted, illegal, alu_instruction_bits};

  localparam logic [24:0] B_PCOUT = 25'h1 << 24;
  localparam logic [24:0] B_PCIN  = 25'h1 << 23;
  localparam logic [24:0] B_INCPC = 25'h1 << 22;
  localparam logic [24:0] B_MARIN = 25'h1 << 21;
  localparam logic [24:0] B_MDRIN = 25'h1 << 20;
  localparam logic [24:0] B_MDROUT= 25'h1 << 19;
  localparam logic [24:0] B_IRIN  = 25'h1 << 18;
  localparam logic [24:0] B_YIN   = 25'h1 << 17;
  localparam logic [24:0] B_ZIN   = 25'h1 << 16;
  localparam logic [24:0] B_ZLOW  = 25'h1 << 15;
  localparam logic [24:0] B_READ  = 25'h1 << 14;
  localparam logic [24:0] B_WRITE = 25'h1 << 13;
  localparam logic [24:0] B_GRA   = 25'h1 << 12;
  localparam logic [24:0] B_GRB   = 25'h1 << 11;
  localparam logic [24:0] B_RIN   = 25'h1 << 10;
  localparam logic [24:0] B_ROUT  = 25'h1 << 9;
  localparam logic [24:0] B_BAOUT = 25'h1 << 8;
  localparam logic [24:0] B_COUT  = 25'h1 << 7;
  localparam logic [24:0] B_HALT  = 25'h1 << 6;
  localparam logic [24:0] B_ILL   = 25'h1 << 5;
  localparam logic [24:0] A_ADD   = 25'd3;

  localparam logic [24:0] W_IDLE = 25'h0;
  localparam logic [24:0] W_F0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [24:0] W_F1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
  localparam logic [24:0] W_F2   = B_MDROUT | B_IRIN;
  localparam logic [24:0] W_X3   = B_GRB | B_BAOUT | B_YIN;
  localparam logic [24:0] W_X4   = B_COUT | B_ZIN | A_ADD;
  localparam logic [24:0] W_X5   = B_ZLOW | B_MARIN;
  localparam logic [24:0] W_LD6  = B_READ | B_MDRIN;
  localparam logic [24:0] W_LD7  = B_MDROUT | B_GRA | B_RIN;
  localparam logic [24:0] W_LI5  = B_ZLOW | B_GRA | B_RIN;
  localparam logic [24:0] W_ST6  = B_GRA | B_ROUT | B_MDRIN | B_WRITE;

  // ---------------- behavioural datapath ----------------
  logic [31:0] mem [0:511];
  logic [31:0] rf  [0:15];
  logic [31:0] pc_r, mdr_r, ir_r, y_r, z_r, bus;
  logic [8:0]  mar_r;
  logic [3:0]  ra, rb;

  assign ra      = ir_r[26:23];
  assign rb      = ir_r[22:19];
  assign IR_Data = IR_in ? bus : ir_r;

  always_comb begin
    bus = 32'h0;
    if (PC_out)        bus = pc_r;
    else if (Zlow_out) bus = z_r;
    else if (MDR_out)  bus = mdr_r;
    else if (Rout)     bus = rf[ra];
    else if (BAout)    bus = (rb == 4'd0) ? 32'h0 : rf[rb];
    else if (C_out)    bus = {{13{ir_r[18]}}, ir_r[18:0]};
  end

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_r <= 32'h0; mar_r <= 9'h0; mdr_r <= 32'h0;
      ir_r <= 32'h0; y_r <= 32'h0;  z_r <= 32'h0;
      rf[3] <= 32'h67;
      rf[4] <= 32'h67;
      if (prog_sel == 0) begin
        mem[0] <= 32'h12000090;  // st $90,R4
        mem[1] <= 32'h00000090;  // ld R0,$90
        mem[2] <= 32'h08980025;  // ldi R1,0x25(R3)
        mem[3] <= 32'h09000005;  // ldi R2,0x5 (Rb=R0 -> base 0)
        mem[4] <= 32'hD0000000;  // nop
        mem[5] <= 32'hD8000000;  // halt
      end else begin
        mem[0] <= 32'hF8000000;  // undefined opcode 11111
      end
    end else begin
      if (MAR_in) mar_r <= bus[8:0];
      if (PC_in)  pc_r  <= bus;
      if (IR_in)  ir_r  <= bus;
      if (Y_in)   y_r   <= bus;
      if (Z_in)   z_r   <= IncPC ? bus + 32'd1 :
                           (alu_instruction_bits == 5'd3) ? y_r + bus : bus;
      if (MDR_in) mdr_r <= Read ? mem[mar_r] : bus;
      if (Write)  mem[mar_r] <= bus;
      if (Rin)    rf[ra] <= bus;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the control word
  task automatic cyc(input string tag, input logic [24:0] exp);
    @(negedge clk);
    chk(tag, {7'h0, word}, {7'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_word", {7'h0, word}, 32'h0);
    chk("reset_count", {16'h0, instr_count}, 32'h0);
    clr = 1'b0;
    cyc("idle_run0", W_IDLE);

    // Clear pulse in the middle of F1
    run = 1'b1;
    cyc("pre_clr_F0", W_F0);
    @(posedge clk); #2;
    clr = 1'b1; #1;
    chk("clr_midF1_word", {7'h0, word}, 32'h0);
    chk("clr_midF1_count", {16'h0, instr_count}, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // st $90,R4
    cyc("st_F0", W_F0); cyc("st_F1", W_F1); cyc("st_F2", W_F2);
    cyc("st_ST3", W_X3); cyc("st_ST4", W_X4); cyc("st_ST5", W_X5);
    cyc("st_ST6", W_ST6);

    // ld R0,$90 with run dropped during LD5
    cyc("ld_F0", W_F0);
    chk("st_mem90", mem[9'h90], 32'h67);
    chk("st_count", {16'h0, instr_count}, 32'd1);
    cyc("ld_F1", W_F1); cyc("ld_F2", W_F2);
    cyc("ld_LD3", W_X3); cyc("ld_LD4", W_X4); cyc("ld_LD5", W_X5);
    run = 1'b0;
    cyc("ld_LD6", W_LD6); cyc("ld_LD7", W_LD7);
    cyc("ld_then_idle", W_IDLE);
    chk("ld_R0", rf[0], 32'h67);
    chk("ld_PC", pc_r, 32'd2);
    chk("ld_count", {16'h0, instr_count}, 32'd2);
    cyc("idle_hold", W_IDLE);

    // ldi R1,0x25(R3) then ldi R2,0x5 with base R0 -> 0
    run = 1'b1;
    cyc("ldi1_F0", W_F0); cyc("ldi1_F1", W_F1); cyc("ldi1_F2", W_F2);
    cyc("ldi1_LI3", W_X3); cyc("ldi1_LI4", W_X4); cyc("ldi1_LI5", W_LI5);
    cyc("ldi2_F0", W_F0);
    chk("ldi1_R1", rf[1], 32'h8C);
    chk("ldi1_count", {16'h0, instr_count}, 32'd3);
    cyc("ldi2_F1", W_F1); cyc("ldi2_F2", W_F2);
    cyc("ldi2_LI3", W_X3); cyc("ldi2_LI4", W_X4); cyc("ldi2_LI5", W_LI5);

    // nop straight into the halt fetch, no gap cycle
    cyc("nop_F0", W_F0);
    chk("ldi2_R2", rf[2], 32'h5);
    cyc("nop_F1", W_F1); cyc("nop_F2", W_F2);
    cyc("halt_F0", W_F0);
    chk("nop_count", {16'h0, instr_count}, 32'd5);
    cyc("halt_F1", W_F1); cyc("halt_F2", W_F2);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) run = 1'b0;
      cyc($sformatf("halt_hold_%0d", i), B_HALT);
    end
    run = 1'b1;
    cyc("halt_run_ignored", B_HALT);
    chk("halt_count", {16'h0, instr_count}, 32'd5);

    // Undefined opcode reaches ERR and stays there
    run = 1'b0;
    prog_sel = 1;
    clr = 1'b1;
    @(negedge clk);
    chk("clr2_word", {7'h0, word}, 32'h0);
    clr = 1'b0;
    run = 1'b1;
    cyc("ill_F0", W_F0); cyc("ill_F1", W_F1); cyc("ill_F2", W_F2);
    for (int i = 0; i < 4; i++) cyc($sformatf("err_hold_%0d", i), B_ILL);
    chk("err_count", {16'h0, instr_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
